// File: rtl/text_console_writer.sv
// text_console_writer
//   Sole bus initiator on the text-mode video card's write port. Accepts a byte
//   stream over valid/ready, keeps a cursor, and turns each byte into
//   character-cell writes (glyphs, CR, LF, backspace, form-feed clear).
//
// Ports
//   clk         in   1   system clock, posedge
//   reset       in   1   asynchronous, active-low reset
//   char_in     in   8   byte to display
//   char_valid  in   1   char_in valid
//   char_ready  out  1   writer can accept (transfer on valid & ready)
//   STB         out  1   write strobe to video card
//   ACK         in   1   video card acknowledge
//   ADDR        out  32  cell address (row*COLS+col), zero-extended
//   DAT_O       out  32  {24'b0, code}
//   busy        out  1   state != IDLE
//   cursor_col  out  7   current column
//   cursor_row  out  6   current row
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for a byte; char_ready may be high
// PUT     | single glyph/blank write, STB high until ACK
// PUT_GAP | STB low for one cycle, cursor updated
// CLR     | blanking the newly entered row, STB high until ACK
// CLR_GAP | STB low for one cycle between row-clear writes
// CLR_ALL | full-screen blank write, STB high until ACK
// ALL_GAP | STB low for one cycle between full-screen writes

module text_console_writer #(
    parameter int         COLS           = 80,
    parameter int         ROWS           = 60,
    parameter logic [7:0] BLANK          = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        STB,
    input  logic        ACK,
    output logic [31:0] ADDR,
    output logic [31:0] DAT_O,
    output logic        busy,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = ($clog2(CELLS) > 13) ? $clog2(CELLS) : 13;

    typedef enum logic [2:0] {
        IDLE, PUT, PUT_GAP, CLR, CLR_GAP, CLR_ALL, ALL_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      col_q, col_d;
    logic [5:0]      row_q, row_d;
    logic [5:0]      tgt_q, tgt_d;       // row being cleared after a row advance
    logic            stb_q, stb_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      dat_q, dat_d;
    logic [AW-1:0]   rem_q, rem_d;       // writes remaining after the current one
    logic            ready_q, ready_d;
    logic            bs_q, bs_d;         // current PUT is a backspace blank
    logic            started_q, started_d;

    logic            accept;
    logic            start_all;
    logic            start_row;
    logic [5:0]      nrow;

    function automatic logic [AW-1:0] cell_addr(input logic [5:0] r, input logic [6:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    assign nrow   = (row_q == 6'(ROWS - 1)) ? 6'd0 : row_q + 6'd1;
    assign accept = (state_q == IDLE) && char_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        tgt_d     = tgt_q;
        stb_d     = stb_q;
        addr_d    = addr_q;
        dat_d     = dat_q;
        rem_d     = rem_q;
        bs_d      = bs_q;
        started_d = 1'b1;
        start_all = 1'b0;
        start_row = 1'b0;

        case (state_q)
            IDLE: begin
                if (CLEAR_ON_RESET && !started_q) begin
                    start_all = 1'b1;
                end else if (accept) begin
                    if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                        addr_d  = cell_addr(row_q, col_q);
                        dat_d   = char_in;
                        bs_d    = 1'b0;
                        stb_d   = 1'b1;
                        state_d = PUT;
                    end else begin
                        case (char_in)
                            8'h0A: start_row = 1'b1;
                            8'h0D: col_d = 7'd0;
                            8'h08: begin
                                if (col_q != 7'd0) begin
                                    addr_d  = cell_addr(row_q, col_q - 7'd1);
                                    dat_d   = BLANK;
                                    bs_d    = 1'b1;
                                    stb_d   = 1'b1;
                                    state_d = PUT;
                                end
                            end
                            8'h0C: start_all = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                if (ACK) begin
                    stb_d   = 1'b0;
                    state_d = PUT_GAP;
                end
            end
            PUT_GAP: begin
                state_d = IDLE;
                if (bs_q) begin
                    col_d = col_q - 7'd1;
                end else if (col_q == 7'(COLS - 1)) begin
                    start_row = 1'b1;
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
            CLR, CLR_ALL: begin
                if (ACK) begin
                    stb_d   = 1'b0;
                    state_d = (state_q == CLR) ? CLR_GAP : ALL_GAP;
                end
            end
            CLR_GAP, ALL_GAP: begin
                if (rem_q == '0) begin
                    col_d   = 7'd0;
                    row_d   = (state_q == CLR_GAP) ? tgt_q : 6'd0;
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_q - 1'b1;
                    addr_d  = addr_q + 1'b1;
                    stb_d   = 1'b1;
                    state_d = (state_q == CLR_GAP) ? CLR : CLR_ALL;
                end
            end
            default: state_d = IDLE;
        endcase

        // Row advance: cursor row moves only once the new row is blank.
        if (start_row) begin
            tgt_d   = nrow;
            addr_d  = cell_addr(nrow, 7'd0);
            rem_d   = AW'(COLS - 1);
            dat_d   = BLANK;
            stb_d   = 1'b1;
            state_d = CLR;
        end
        if (start_all) begin
            addr_d  = '0;
            rem_d   = AW'(CELLS - 1);
            dat_d   = BLANK;
            stb_d   = 1'b1;
            state_d = CLR_ALL;
        end

        // Registered ready: drops for at least one cycle after every accept.
        ready_d = (state_d == IDLE) && !accept;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            tgt_q     <= '0;
            stb_q     <= 1'b0;
            addr_q    <= '0;
            dat_q     <= '0;
            rem_q     <= '0;
            ready_q   <= 1'b0;
            bs_q      <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            tgt_q     <= tgt_d;
            stb_q     <= stb_d;
            addr_q    <= addr_d;
            dat_q     <= dat_d;
            rem_q     <= rem_d;
            ready_q   <= ready_d;
            bs_q      <= bs_d;
            started_q <= started_d;
        end
    end

    assign char_ready = ready_q;
    assign STB        = stb_q;
    assign ADDR       = {{(32 - AW){1'b0}}, addr_q};
    assign DAT_O      = {24'b0, dat_q};
    assign busy       = (state_q != IDLE);
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        STB;
    logic        ACK;
    logic [31:0] ADDR;
    logic [31:0] DAT_O;
    logic        busy;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;

    int total = 0;
    int bad   = 0;

    text_console_writer dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .STB        (STB),
        .ACK        (ACK),
        .ADDR       (ADDR),
        .DAT_O      (DAT_O),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    // Video card model: registered ACK pulse after ack_dly extra cycles of STB.
    int   ack_dly   = 0;
    int   ack_cnt   = 0;
    logic ack_card  = 1'b0;
    logic ack_stray = 1'b0;
    assign ACK = ack_card | ack_stray;

    always @(posedge clk) begin
        if (!STB || ack_card) begin
            ack_card <= 1'b0;
            ack_cnt  <= 0;
        end else if (ack_cnt >= ack_dly) begin
            ack_card <= 1'b1;
        end else begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    // Bus monitor: logs completed writes and protocol violations.
    logic [31:0] log_addr[$];
    logic [31:0] log_dat[$];
    int          rises    = 0;
    int          stab_err = 0;
    int          gap_err  = 0;
    int          low_run  = 0;
    logic        prev_stb  = 1'b0;
    logic        prev_busy = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_dat  = '0;

    always @(negedge clk) begin
        if (STB && ACK) begin
            log_addr.push_back(ADDR);
            log_dat.push_back(DAT_O);
        end
        if (STB && prev_stb && (ADDR !== prev_addr || DAT_O !== prev_dat)) stab_err++;
        if (STB && !prev_stb) begin
            rises++;
            if (prev_busy && low_run != 1) gap_err++;
        end
        low_run   = STB ? 0 : low_run + 1;
        prev_stb  = STB;
        prev_busy = busy;
        prev_addr = ADDR;
        prev_dat  = DAT_O;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog global time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        char_valid = 1'b0;
        ack_stray  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, output int cyc);
        int n;
        n = 0;
        while (!char_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            total++;
            bad++;
            $display("FAIL send_ready_timeout got=%b want=1", char_ready);
        end
        char_in    = b;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        cyc = 0;
        while (!(char_ready && !busy) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40000) begin
            total++;
            bad++;
            $display("FAIL send_done_timeout byte=%0h busy=%b want idle", b, busy);
        end
    endtask

    task automatic send_n(input logic [7:0] b, input int count);
        int c;
        for (int i = 0; i < count; i++) send(b, c);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (STB !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b want=0", STB); end
        total++; if (ADDR !== 32'd0) begin bad++; $display("FAIL rst_addr got=%0h want=0", ADDR); end
        total++; if (DAT_O !== 32'd0) begin bad++; $display("FAIL rst_dat got=%0h want=0", DAT_O); end
        total++; if (char_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", char_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if ({cursor_col, cursor_row} !== 13'd0) begin bad++; $display("FAIL rst_cursor got=(%0d,%0d) want=(0,0)", cursor_col, cursor_row); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (char_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", char_ready); end
    endtask

    task automatic test_put();
        int b, cyc;
        b = log_addr.size();
        send(8'h41, cyc);
        total++; if (log_addr.size() - b !== 1) begin bad++; $display("FAIL put_count got=%0d want=1", log_addr.size() - b); end
        if (log_addr.size() > b) begin
            total++; if (log_addr[b] !== 32'd0) begin bad++; $display("FAIL put_addr got=%0h want=0", log_addr[b]); end
            total++; if (log_dat[b] !== 32'h41) begin bad++; $display("FAIL put_dat got=%0h want=41", log_dat[b]); end
        end
        total++; if (cursor_col !== 7'd1 || cursor_row !== 6'd0) begin bad++; $display("FAIL put_cursor got=(%0d,%0d) want=(1,0)", cursor_col, cursor_row); end
        total++; if (cyc !== 3) begin bad++; $display("FAIL put_cycles got=%0d want=3", cyc); end
        total++; if (char_ready !== 1'b1) begin bad++; $display("FAIL put_ready got=%b want=1", char_ready); end
    endtask

    task automatic test_wrap();
        int b, cyc, errs, first;
        do_reset();
        send_n(8'h42, 79);
        b = log_addr.size();
        send(8'h5A, cyc);
        total++; if (log_addr.size() - b !== 81) begin bad++; $display("FAIL wrap_count got=%0d want=81", log_addr.size() - b); end
        if (log_addr.size() - b >= 81) begin
            total++; if (log_addr[b] !== 32'd79 || log_dat[b] !== 32'h5A) begin bad++; $display("FAIL wrap_glyph got=%0d/%0h want=79/5a", log_addr[b], log_dat[b]); end
            errs = 0; first = -1;
            for (int i = 0; i < 80; i++)
                if (log_addr[b+1+i] !== 32'(80 + i) || log_dat[b+1+i] !== 32'h20) begin
                    errs++; if (first < 0) first = i;
                end
            total++; if (errs !== 0) begin bad++; $display("FAIL wrap_clear errors=%0d first_index=%0d want=0", errs, first); end
        end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 6'd1) begin bad++; $display("FAIL wrap_cursor got=(%0d,%0d) want=(0,1)", cursor_col, cursor_row); end
    endtask

    task automatic test_lf_cr();
        int b, r, cyc, errs;
        do_reset();
        send_n(8'h0A, 59);
        send_n(8'h43, 5);
        total++; if (cursor_col !== 7'd5 || cursor_row !== 6'd59) begin bad++; $display("FAIL lf_setup got=(%0d,%0d) want=(5,59)", cursor_col, cursor_row); end
        b = log_addr.size();
        send(8'h0A, cyc);
        total++; if (log_addr.size() - b !== 80) begin bad++; $display("FAIL lf_count got=%0d want=80", log_addr.size() - b); end
        if (log_addr.size() - b >= 80) begin
            errs = 0;
            for (int i = 0; i < 80; i++)
                if (log_addr[b+i] !== 32'(i) || log_dat[b+i] !== 32'h20) errs++;
            total++; if (errs !== 0) begin bad++; $display("FAIL lf_wrap_clear errors=%0d want=0", errs); end
        end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin bad++; $display("FAIL lf_cursor got=(%0d,%0d) want=(0,0)", cursor_col, cursor_row); end
        send_n(8'h0A, 3);
        send_n(8'h44, 5);
        r = rises;
        send(8'h0D, cyc);
        total++; if (rises !== r) begin bad++; $display("FAIL cr_stb got=%0d strobes want=0", rises - r); end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 6'd3) begin bad++; $display("FAIL cr_cursor got=(%0d,%0d) want=(0,3)", cursor_col, cursor_row); end
        total++; if (cyc !== 1) begin bad++; $display("FAIL cr_cycles got=%0d want=1", cyc); end
        send_n(8'h45, 2);
        r = rises;
        send(8'h01, cyc);
        total++; if (rises !== r || cursor_col !== 7'd2 || cursor_row !== 6'd3) begin bad++; $display("FAIL other_byte got strobes=%0d cursor=(%0d,%0d) want 0,(2,3)", rises - r, cursor_col, cursor_row); end
    endtask

    task automatic test_backspace();
        int b, r, cyc;
        do_reset();
        send_n(8'h0A, 2);
        send_n(8'h46, 3);
        b = log_addr.size();
        send(8'h08, cyc);
        total++; if (log_addr.size() - b !== 1) begin bad++; $display("FAIL bs_count got=%0d want=1", log_addr.size() - b); end
        if (log_addr.size() > b) begin
            total++; if (log_addr[b] !== 32'd162 || log_dat[b] !== 32'h20) begin bad++; $display("FAIL bs_write got=%0d/%0h want=162/20", log_addr[b], log_dat[b]); end
        end
        total++; if (cursor_col !== 7'd2 || cursor_row !== 6'd2) begin bad++; $display("FAIL bs_cursor got=(%0d,%0d) want=(2,2)", cursor_col, cursor_row); end
        send_n(8'h08, 2);
        r = rises;
        send(8'h08, cyc);
        total++; if (rises !== r) begin bad++; $display("FAIL bs_col0_stb got=%0d strobes want=0", rises - r); end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 6'd2) begin bad++; $display("FAIL bs_col0_cursor got=(%0d,%0d) want=(0,2)", cursor_col, cursor_row); end
    endtask

    task automatic test_clear_all();
        int b, r, s0, g0, n, busylow, errs;
        do_reset();
        send_n(8'h0A, 1);
        send_n(8'h47, 4);
        ack_dly = 3;
        b = log_addr.size(); r = rises; s0 = stab_err; g0 = gap_err;
        char_in    = 8'h0C;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        n = 0; busylow = 0;
        while (log_addr.size() - b < 4800 && n < 60000) begin
            if (!busy) busylow++;
            @(negedge clk);
            n++;
        end
        while (!(char_ready && !busy) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        ack_dly = 0;
        total++; if (n >= 60000) begin bad++; $display("FAIL ff_timeout cycles=%0d want<60000", n); end
        total++; if (log_addr.size() - b !== 4800) begin bad++; $display("FAIL ff_count got=%0d want=4800", log_addr.size() - b); end
        total++; if (rises - r !== 4800) begin bad++; $display("FAIL ff_strobes got=%0d want=4800", rises - r); end
        if (log_addr.size() - b >= 4800) begin
            errs = 0;
            for (int i = 0; i < 4800; i++)
                if (log_addr[b+i] !== 32'(i) || log_dat[b+i] !== 32'h20) errs++;
            total++; if (errs !== 0) begin bad++; $display("FAIL ff_sequence errors=%0d want=0", errs); end
        end
        total++; if (stab_err - s0 !== 0) begin bad++; $display("FAIL ff_stable got=%0d violations want=0", stab_err - s0); end
        total++; if (gap_err - g0 !== 0) begin bad++; $display("FAIL ff_gap got=%0d violations want=0", gap_err - g0); end
        total++; if (busylow !== 0) begin bad++; $display("FAIL ff_busy got=%0d idle samples want=0", busylow); end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin bad++; $display("FAIL ff_cursor got=(%0d,%0d) want=(0,0)", cursor_col, cursor_row); end
    endtask

    task automatic test_reset_midclear();
        int n, r, b, cyc;
        do_reset();
        send_n(8'h48, 2);
        char_in    = 8'h0C;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        repeat (200) @(negedge clk);
        n = 0;
        while (!(ACK && STB) && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++; if (!(ACK && STB)) begin bad++; $display("FAIL mid_ack_seen got=%b%b want=11", STB, ACK); end
        reset = 1'b0;
        #1;
        total++; if (STB !== 1'b0) begin bad++; $display("FAIL mid_stb got=%b want=0", STB); end
        total++; if (busy !== 1'b0 || ADDR !== 32'd0) begin bad++; $display("FAIL mid_state got busy=%b addr=%0h want 0,0", busy, ADDR); end
        total++; if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin bad++; $display("FAIL mid_cursor got=(%0d,%0d) want=(0,0)", cursor_col, cursor_row); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (char_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", char_ready); end
        r = rises;
        ack_stray = 1'b1;
        repeat (3) @(negedge clk);
        ack_stray = 1'b0;
        total++; if (busy !== 1'b0 || STB !== 1'b0 || char_ready !== 1'b1 || rises !== r) begin
            bad++; $display("FAIL stray_ack got busy=%b stb=%b ready=%b strobes=%0d want 0,0,1,0", busy, STB, char_ready, rises - r);
        end
        b = log_addr.size();
        send(8'h49, cyc);
        total++; if (log_addr.size() - b !== 1 || (log_addr.size() > b && (log_addr[b] !== 32'd0 || log_dat[b] !== 32'h49))) begin
            bad++; $display("FAIL post_reset_put got count=%0d want 1 write 0/49", log_addr.size() - b);
        end
    endtask

    initial begin
        test_reset();
        test_put();
        test_wrap();
        test_lf_cr();
        test_backspace();
        test_clear_all();
        test_reset_midclear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
